// File: rtl/dkong_obj_linebuf.sv
// dkong_obj_linebuf: double-banked 256x6 object line buffer, clear-after-read.
// Macro OBJ_PRIORITY_LAST_EN: last opaque write wins, one pixel per cycle.
module dkong_obj_linebuf (
  input  logic       CLK_6M,
  input  logic       W_1EF_RST,
  input  logic       I_LSTART,
  input  logic       I_WR_VALID,
  output logic       O_WR_READY,
  input  logic [7:0] I_WR_X,
  input  logic [5:0] I_WR_PIX,
  input  logic       I_RD_EN,
  input  logic [7:0] I_RD_X,
  output logic [5:0] O_OBJ_D,
  output logic [8:0] O_WR_CNT
);

  typedef enum logic {W_IDLE, W_CHK} wst_e;

  wst_e       st_q, st_d;
  logic       bank_sel_q, bank_sel_d;
  logic [1:0] lcnt_q, lcnt_d;
  logic [8:0] cnt_q, cnt_d;
  logic [5:0] obj_q, obj_d;

  logic [5:0] mem0 [256];
  logic [5:0] mem1 [256];

  logic       wr_en;
  logic [7:0] wr_addr;
  logic [5:0] wr_data;
  logic [5:0] rd_cur;
  logic       valid;

`ifndef OBJ_PRIORITY_LAST_EN
  logic [7:0] wx_q, wx_d;
  logic [5:0] wp_q, wp_d;
  logic [1:0] old_lo;

  assign old_lo = bank_sel_q ? mem1[wx_q][1:0]
                             : mem0[wx_q][1:0];
`endif

  assign rd_cur = bank_sel_q ? mem0[I_RD_X]
                             : mem1[I_RD_X];
  // RAM is not reset; stay dark until both banks saw a read pass
  assign valid  = (lcnt_q == 2'd2);

  always_comb begin
    st_d       = st_q;
    O_WR_READY = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = I_WR_X;
    wr_data    = I_WR_PIX;
`ifdef OBJ_PRIORITY_LAST_EN
    unique case (st_q)
      W_IDLE: st_d = W_IDLE;
      W_CHK:  st_d = W_IDLE;
      default: st_d = W_IDLE;
    endcase
    wr_en = I_WR_VALID && (I_WR_PIX[1:0] != 2'b00);
`else
    wx_d    = wx_q;
    wp_d    = wp_q;
    wr_addr = wx_q;
    wr_data = wp_q;
    unique case (st_q)
      W_IDLE: begin
        if (I_WR_VALID) begin
          wx_d = I_WR_X;
          wp_d = I_WR_PIX;
          st_d = W_CHK;
        end
      end
      W_CHK: begin
        O_WR_READY = 1'b0;
        st_d       = W_IDLE;
        wr_en      = !I_LSTART
                  && (wp_q[1:0] != 2'b00)
                  && (old_lo == 2'b00);
      end
      default: st_d = W_IDLE;
    endcase
`endif
  end

  always_comb begin
    bank_sel_d = bank_sel_q ^ I_LSTART;
    lcnt_d     = lcnt_q;
    if (I_LSTART && !valid)
      lcnt_d = lcnt_q + 2'd1;
    cnt_d = cnt_q;
    if (I_LSTART)
      cnt_d = 9'd0;
    else if (wr_en && (cnt_q != 9'd511))
      cnt_d = cnt_q + 9'd1;
    obj_d = 6'd0;
    if (I_RD_EN && valid)
      obj_d = rd_cur;
  end

  always_ff @(posedge CLK_6M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      st_q       <= W_IDLE;
      bank_sel_q <= 1'b0;
      lcnt_q     <= 2'd0;
      cnt_q      <= 9'd0;
      obj_q      <= 6'd0;
`ifndef OBJ_PRIORITY_LAST_EN
      wx_q       <= 8'd0;
      wp_q       <= 6'd0;
`endif
    end else begin
      st_q       <= st_d;
      bank_sel_q <= bank_sel_d;
      lcnt_q     <= lcnt_d;
      cnt_q      <= cnt_d;
      obj_q      <= obj_d;
`ifndef OBJ_PRIORITY_LAST_EN
      wx_q       <= wx_d;
      wp_q       <= wp_d;
`endif
    end
  end

  // Write bank and read bank are always distinct, so no port conflict
  always_ff @(posedge CLK_6M) begin
    if (W_1EF_RST) begin
      if (wr_en && !bank_sel_q)
        mem0[wr_addr] <= wr_data;
      if (I_RD_EN && bank_sel_q)
        mem0[I_RD_X] <= 6'd0;
      if (wr_en && bank_sel_q)
        mem1[wr_addr] <= wr_data;
      if (I_RD_EN && !bank_sel_q)
        mem1[I_RD_X] <= 6'd0;
    end
  end

  assign O_OBJ_D  = obj_q;
  assign O_WR_CNT = cnt_q;

endmodule

// File: tb/tb_dkong_obj_linebuf.sv
// tb_dkong_obj_linebuf: randomized and directed checks of the object line
// buffer against a line-level bank model.
module tb_dkong_obj_linebuf;

  logic       CLK_6M = 1'b0;
  logic       W_1EF_RST = 1'b0;
  logic       I_LSTART = 1'b0;
  logic       I_WR_VALID = 1'b0;
  logic [7:0] I_WR_X = 8'd0;
  logic [5:0] I_WR_PIX = 6'd0;
  logic       I_RD_EN = 1'b0;
  logic [7:0] I_RD_X = 8'd0;
  logic       O_WR_READY;
  logic [5:0] O_OBJ_D;
  logic [8:0] O_WR_CNT;

  dkong_obj_linebuf dut (
    .CLK_6M    (CLK_6M),
    .W_1EF_RST (W_1EF_RST),
    .I_LSTART  (I_LSTART),
    .I_WR_VALID(I_WR_VALID),
    .O_WR_READY(O_WR_READY),
    .I_WR_X    (I_WR_X),
    .I_WR_PIX  (I_WR_PIX),
    .I_RD_EN   (I_RD_EN),
    .I_RD_X    (I_RD_X),
    .O_OBJ_D   (O_OBJ_D),
    .O_WR_CNT  (O_WR_CNT)
  );

  always #5 CLK_6M = ~CLK_6M;

  int n_chk = 0;
  int n_err = 0;

  // line-level model: two banks, write bank = sel, line-start count
  logic [5:0] mb [2][256];
  bit         m_sel;
  int         m_lc;
  int         m_cnt;
  bit         m_rdy;
  bit         m_pend;
  logic [7:0] m_px;
  logic [5:0] m_pp;
  logic [5:0] e_obj;
  bit         e_rdy;
  int         e_cnt;

  task automatic model_reset();
    m_sel = 1'b0; m_lc = 0; m_cnt = 0;
    m_rdy = 1'b1; m_pend = 1'b0;
    e_obj = 6'd0; e_rdy = 1'b1; e_cnt = 0;
  endtask

  // drive one cycle, predict outputs after the edge, step past it
  task automatic cyc(input bit lst, input bit wv, input logic [7:0] wx,
                     input logic [5:0] wp, input bit re,
                     input logic [7:0] rx);
    bit acc;
    bit inc;
    I_LSTART = lst; I_WR_VALID = wv; I_WR_X = wx; I_WR_PIX = wp;
    I_RD_EN = re; I_RD_X = rx;
    acc = wv && m_rdy;
    inc = 1'b0;
    e_obj = (re && m_lc >= 2) ? mb[!m_sel][rx] : 6'd0;
    if (re) mb[!m_sel][rx] = 6'd0;
`ifdef OBJ_PRIORITY_LAST_EN
    if (acc && wp[1:0] != 2'b00) begin
      mb[m_sel][wx] = wp; inc = 1'b1;
    end
    m_rdy = 1'b1;
`else
    if (m_pend && !lst && m_pp[1:0] != 2'b00
        && mb[m_sel][m_px][1:0] == 2'b00) begin
      mb[m_sel][m_px] = m_pp; inc = 1'b1;
    end
    m_pend = acc; m_px = wx; m_pp = wp;
    m_rdy = !acc;
`endif
    if (lst) begin
      m_sel = !m_sel; if (m_lc < 2) m_lc++; m_cnt = 0;
    end else if (inc && m_cnt != 511) m_cnt++;
    e_rdy = m_rdy; e_cnt = m_cnt;
    @(posedge CLK_6M); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    model_reset();
    W_1EF_RST = 1'b0;
    repeat (3) @(posedge CLK_6M);
    #1;
    n_chk++;
    if (O_WR_READY !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got=%b exp=1", O_WR_READY);
    end
    n_chk++;
    if (O_OBJ_D !== 6'd0) begin
      n_err++; $display("FAIL reset_obj got=%h exp=00", O_OBJ_D);
    end
    n_chk++;
    if (O_WR_CNT !== 9'd0) begin
      n_err++; $display("FAIL reset_cnt got=%0d exp=0", O_WR_CNT);
    end
    W_1EF_RST = 1'b1;
    idle();
  endtask

  task automatic test_clear_pass();
    for (int ln = 0; ln < 3; ln++) begin
      for (int i = 0; i < 256; i++) begin
        cyc(1'b0, 1'b0, 8'd0, 6'd0, 1'b1, 8'(i));
        n_chk++;
        if (O_OBJ_D !== 6'd0) begin
          n_err++;
          $display("FAIL clear_pass line=%0d x=%0d got=%h exp=00",
                   ln, i, O_OBJ_D);
        end
      end
      cyc(ln < 2, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
    end
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) mb[b][i] = 6'd0;
  endtask

  task automatic test_basic();
    cyc(1'b0, 1'b1, 8'd10, 6'h25, 1'b0, 8'd0);
    idle();
    n_chk++;
    if (O_WR_CNT !== 9'd1 || O_WR_CNT !== 9'(e_cnt)) begin
      n_err++; $display("FAIL basic_cnt got=%0d exp=1", O_WR_CNT);
    end
    cyc(1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
    n_chk++;
    if (O_WR_CNT !== 9'd0) begin
      n_err++; $display("FAIL basic_cnt_clr got=%0d exp=0", O_WR_CNT);
    end
    cyc(1'b0, 1'b0, 8'd0, 6'd0, 1'b1, 8'd10);
    n_chk++;
    if (O_OBJ_D !== 6'h25 || O_OBJ_D !== e_obj) begin
      n_err++; $display("FAIL basic_read got=%h exp=25", O_OBJ_D);
    end
    cyc(1'b0, 1'b0, 8'd0, 6'd0, 1'b1, 8'd10);
    n_chk++;
    if (O_OBJ_D !== 6'h00) begin
      n_err++; $display("FAIL basic_reread got=%h exp=00", O_OBJ_D);
    end
    idle();
    n_chk++;
    if (O_OBJ_D !== 6'h00) begin
      n_err++; $display("FAIL basic_rd_off got=%h exp=00", O_OBJ_D);
    end
  endtask

  task automatic test_priority();
    logic [5:0] exp_pix;
    int exp_cnt;
`ifdef OBJ_PRIORITY_LAST_EN
    exp_pix = 6'h3E; exp_cnt = 2;
`else
    exp_pix = 6'h11; exp_cnt = 1;
`endif
    cyc(1'b0, 1'b1, 8'd20, 6'h11, 1'b0, 8'd0);
    idle();
    cyc(1'b0, 1'b1, 8'd20, 6'h3E, 1'b0, 8'd0);
    idle();
    n_chk++;
    if (O_WR_CNT !== 9'(exp_cnt)) begin
      n_err++;
      $display("FAIL prio_cnt got=%0d exp=%0d", O_WR_CNT, exp_cnt);
    end
    cyc(1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0, 6'd0, 1'b1, 8'd20);
    n_chk++;
    if (O_OBJ_D !== exp_pix || O_OBJ_D !== e_obj) begin
      n_err++;
      $display("FAIL prio_read got=%h exp=%h", O_OBJ_D, exp_pix);
    end
    idle();
  endtask

  task automatic test_transparent();
    cyc(1'b0, 1'b1, 8'd5, 6'h04, 1'b0, 8'd0);
    idle();
    n_chk++;
    if (O_WR_CNT !== 9'd0) begin
      n_err++; $display("FAIL transp_cnt got=%0d exp=0", O_WR_CNT);
    end
    cyc(1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0, 6'd0, 1'b1, 8'd5);
    n_chk++;
    if (O_OBJ_D !== 6'h00) begin
      n_err++; $display("FAIL transp_read got=%h exp=00", O_OBJ_D);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    bit exp_r;
    logic [5:0] p;
    for (int k = 0; k < 16; k++) begin
      p = {4'(k), 2'b01};
      cyc(1'b0, 1'b1, 8'(100 + k), p, 1'b0, 8'd0);
`ifdef OBJ_PRIORITY_LAST_EN
      exp_r = 1'b1;
`else
      exp_r = (k % 2 == 1);
`endif
      n_chk++;
      if (O_WR_READY !== exp_r || O_WR_READY !== e_rdy) begin
        n_err++;
        $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, O_WR_READY, exp_r);
      end
    end
    n_chk++;
`ifdef OBJ_PRIORITY_LAST_EN
    if (O_WR_CNT !== 9'd16) begin
      n_err++; $display("FAIL b2b_cnt got=%0d exp=16", O_WR_CNT);
    end
`else
    if (O_WR_CNT !== 9'd8) begin
      n_err++; $display("FAIL b2b_cnt got=%0d exp=8", O_WR_CNT);
    end
`endif
    cyc(1'b0, 1'b1, 8'd200, 6'h3D, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
    n_chk++;
    if (O_WR_CNT !== 9'd0 || O_WR_READY !== 1'b1) begin
      n_err++;
      $display("FAIL drop_state cnt=%0d rdy=%b exp cnt=0 rdy=1",
               O_WR_CNT, O_WR_READY);
    end
    cyc(1'b0, 1'b0, 8'd0, 6'd0, 1'b1, 8'd200);
    n_chk++;
    if (O_OBJ_D !== e_obj) begin
      n_err++; $display("FAIL drop_read got=%h exp=%h", O_OBJ_D, e_obj);
    end
    cyc(1'b0, 1'b0, 8'd0, 6'd0, 1'b1, 8'd100);
    n_chk++;
    if (O_OBJ_D !== 6'h01) begin
      n_err++; $display("FAIL b2b_read got=%h exp=01", O_OBJ_D);
    end
    idle();
  endtask

  task automatic test_random();
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < 60; c++) begin
        cyc(1'b0, 1'($urandom % 2), 8'($urandom % 32),
            6'($urandom), 1'($urandom % 2), 8'($urandom % 32));
        n_chk++;
        if (O_OBJ_D !== e_obj || O_WR_READY !== e_rdy) begin
          n_err++;
          $display("FAIL rand line=%0d c=%0d obj=%h/%h rdy=%b/%b",
                   ln, c, O_OBJ_D, e_obj, O_WR_READY, e_rdy);
        end
      end
      idle();
      n_chk++;
      if (O_WR_CNT !== 9'(e_cnt)) begin
        n_err++;
        $display("FAIL rand_cnt line=%0d got=%0d exp=%0d",
                 ln, O_WR_CNT, e_cnt);
      end
      cyc(1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
    end
  endtask

  task automatic test_reset_midwrite();
    cyc(1'b0, 1'b1, 8'd60, 6'h2A, 1'b0, 8'd0);
    idle();
    cyc(1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd50, 6'h07, 1'b1, 8'd60);
    n_chk++;
    if (O_OBJ_D !== 6'h2A || O_WR_READY !== e_rdy) begin
      n_err++;
      $display("FAIL midwr_pre obj=%h/2a rdy=%b/%b",
               O_OBJ_D, O_WR_READY, e_rdy);
    end
    I_WR_VALID = 1'b0; I_RD_EN = 1'b0;
    #2 W_1EF_RST = 1'b0;
    #1;
    n_chk++;
    if (O_WR_READY !== 1'b1 || O_OBJ_D !== 6'd0 || O_WR_CNT !== 9'd0) begin
      n_err++;
      $display("FAIL midwr_rst rdy=%b obj=%h cnt=%0d exp 1/00/0",
               O_WR_READY, O_OBJ_D, O_WR_CNT);
    end
    @(posedge CLK_6M); #1;
    W_1EF_RST = 1'b1;
    model_reset();
    idle();
  endtask

  initial begin
    test_reset();
    test_clear_pass();
    test_basic();
    test_priority();
    test_transparent();
    test_back_to_back();
    test_random();
    test_reset_midwrite();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
